// File: rtl/acc_pkg.sv
// acc_pkg
// Shared definitions for the sequential accumulator ALU slice:
//   DATA_W    - datapath width (fixed at 8 bits)
//   MUL_STEPS - number of shift-add steps, one per multiplier bit
//   opcode_e  - 3-bit operation select
//   state_e   - control FSM state encoding
package acc_pkg;

    localparam int DATA_W = 8;

    localparam logic [3:0] MUL_STEPS = 4'd8;

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_MUL  = 3'b110,
        OP_CLR  = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_MUL   = 2'd2,
        S_WRITE = 2'd3
    } state_e;

endpackage

// File: rtl/accreg8bit.sv
// accreg8bit
// 8-bit accumulator register that closes the loop around acc_alu_seq.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset, clears q
//   ldacc  in   load strobe
//   en     in   enable; q captures d only when ldacc and en are both high
//   d      in   next accumulator value
//   q      out  current accumulator value
module accreg8bit
    import acc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ldacc,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Capture the ALU result only on a qualified write strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (ldacc && en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/alu8_comb.sv
// alu8_comb
// Purely combinational 8-bit ALU covering every opcode except MUL, which is
// built as a multi-cycle shift-add datapath in acc_alu_seq instead.
// Ports:
//   opcode  in   operation select
//   a       in   operand A (accumulator value)
//   b       in   operand B
//   result  out  operation result, modulo 256
//   carry   out  ADD carry-out / SUB borrow; 0 for all other opcodes
module alu8_comb
    import acc_pkg::*;
(
    input  opcode_e           opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] sum;

    // Select the result for the requested operation. The 9-bit sum gives the
    // ADD carry in its top bit; SUB flags a borrow whenever B exceeds A.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        result = '0;
        carry  = 1'b0;
        case (opcode)
            OP_LOAD: result = b;
            OP_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            OP_SUB: begin
                result = a - b;
                carry  = (b > a);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/acc_alu_seq.sv
// acc_alu_seq
// Sequential accumulator ALU. Accepts one operation at a time through a
// valid/ready handshake, computes it against the external accumulator value,
// then issues a one-cycle write strobe back to the accumulator register.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   op_valid  in   upstream offers an operation
//   op_ready  out  operation can be accepted this cycle (IDLE only)
//   opcode    in   operation select
//   operand   in   operand B
//   acc_q     in   accumulator output, operand A
//   acc_d     out  result, held between writes
//   ldacc     out  accumulator load strobe (WRITE only)
//   en        out  accumulator enable (WRITE only)
//   carry     out  carry/borrow/overflow flag of the last written result
//   zero      out  last written result was zero
//   busy      out  operation in progress
module acc_alu_seq
    import acc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        opcode,
    input  logic [DATA_W-1:0] operand,
    input  logic [DATA_W-1:0] acc_q,
    output logic [DATA_W-1:0] acc_d,
    output logic              ldacc,
    output logic              en,
    output logic              carry,
    output logic              zero,
    output logic              busy
);

    state_e state, state_next;

    logic                accept;
    opcode_e             op_reg;
    logic [DATA_W-1:0]   a_reg;
    logic [DATA_W-1:0]   b_reg;
    logic [2*DATA_W-1:0] product;
    logic [2*DATA_W-1:0] mcand;
    logic [DATA_W-1:0]   mplier;
    logic [3:0]          mul_cnt;
    logic [DATA_W-1:0]   result_reg;
    logic                carry_pend;
    logic                carry_reg;
    logic                zero_reg;

    logic [DATA_W-1:0]   alu_result;
    logic                alu_carry;

    alu8_comb u_alu (
        .opcode (op_reg),
        .a      (a_reg),
        .b      (b_reg),
        .result (alu_result),
        .carry  (alu_carry)
    );

    assign accept = op_valid && op_ready;
    assign acc_d  = result_reg;
    assign carry  = carry_reg;
    assign zero   = zero_reg;

    // State register. Reset wins over everything, so an operation in flight
    // is simply dropped and no write strobe is ever produced for it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/strobe decode. The MUL state runs eight
    // shift-add steps (mul_cnt 0..7) followed by one commit cycle
    // (mul_cnt 8) that moves the finished product into the result register,
    // giving a ten-cycle accept-to-write latency.
    always_comb begin
        state_next = state;
        op_ready   = 1'b0;
        busy       = 1'b1;
        ldacc      = 1'b0;
        en         = 1'b0;
        case (state)
            S_IDLE: begin
                op_ready = 1'b1;
                busy     = 1'b0;
                if (op_valid) begin
                    state_next = (opcode_e'(opcode) == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: state_next = S_WRITE;
            S_MUL: begin
                if (mul_cnt == MUL_STEPS) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                ldacc      = 1'b1;
                en         = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath registers. Operands are captured on the accept edge. The
    // result register is loaded on the edge entering WRITE so acc_d already
    // carries the new value while the strobe is high, then simply holds.
    // The flags are published on the edge that ends WRITE, in step with the
    // accumulator capturing acc_d.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg     <= OP_LOAD;
            a_reg      <= '0;
            b_reg      <= '0;
            product    <= '0;
            mcand      <= '0;
            mplier     <= '0;
            mul_cnt    <= '0;
            result_reg <= '0;
            carry_pend <= 1'b0;
            carry_reg  <= 1'b0;
            zero_reg   <= 1'b0;
        end else begin
            if (accept) begin
                op_reg  <= opcode_e'(opcode);
                a_reg   <= acc_q;
                b_reg   <= operand;
                product <= '0;
                mcand   <= {{DATA_W{1'b0}}, acc_q};
                mplier  <= operand;
                mul_cnt <= '0;
            end
            case (state)
                S_EXEC: begin
                    result_reg <= alu_result;
                    carry_pend <= alu_carry;
                end
                S_MUL: begin
                    if (mul_cnt < MUL_STEPS) begin
                        if (mplier[0]) begin
                            product <= product + mcand;
                        end
                        mcand   <= mcand << 1;
                        mplier  <= mplier >> 1;
                        mul_cnt <= mul_cnt + 4'd1;
                    end else begin
                        result_reg <= product[DATA_W-1:0];
                        carry_pend <= |product[2*DATA_W-1:DATA_W];
                    end
                end
                S_WRITE: begin
                    carry_reg <= carry_pend;
                    zero_reg  <= (result_reg == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_alu_seq.sv
// tb_acc_alu_seq
// Closed-loop bench: acc_alu_seq drives accreg8bit, whose output feeds back
// as operand A. Directed vectors with hand-computed results are applied from
// a table, followed by hand-written reset-abort and back-to-back sequences.
module tb_acc_alu_seq;

    logic       clk;
    logic       rst;
    logic       acc_rst;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] opcode;
    logic [7:0] operand;
    logic [7:0] acc_q;
    logic [7:0] acc_d;
    logic       ldacc;
    logic       en;
    logic       carry;
    logic       zero;
    logic       busy;

    int checks;
    int errors;
    int pulse_count;

    acc_alu_seq dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .opcode   (opcode),
        .operand  (operand),
        .acc_q    (acc_q),
        .acc_d    (acc_d),
        .ldacc    (ldacc),
        .en       (en),
        .carry    (carry),
        .zero     (zero),
        .busy     (busy)
    );

    accreg8bit u_acc (
        .clk   (clk),
        .rst   (acc_rst),
        .ldacc (ldacc),
        .en    (en),
        .d     (acc_d),
        .q     (acc_q)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count every write strobe the accumulator sees.
    initial pulse_count = 0;
    always @(posedge clk) begin
        if (ldacc && en) pulse_count = pulse_count + 1;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [2:0] op;
        logic [7:0] b;
        logic [7:0] exp_res;
        logic       exp_carry;
        logic       exp_zero;
        int         exp_lat;
    } vec_t;

    vec_t vecs[18];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Offer one operation, wait for it to be accepted, then wait for the
    // write strobe. Returns at the negedge where the strobe is visible,
    // with lat = whole cycles from the accept edge to the write edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] b, output int lat);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!op_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!op_ready) checkOutput("ready_wait", int'(op_ready), 1);
        opcode   = op;
        operand  = b;
        op_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        lat = 1;
        while (!ldacc && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int base;

        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        acc_rst  = 1'b1;
        op_valid = 1'b0;
        opcode   = 3'b000;
        operand  = 8'd0;

        vecs[0]  = '{3'b000, 8'd1,   8'd1,   1'b0, 1'b0, 2};
        vecs[1]  = '{3'b000, 8'd200, 8'd200, 1'b0, 1'b0, 2};
        vecs[2]  = '{3'b001, 8'd100, 8'd44,  1'b1, 1'b0, 2};
        vecs[3]  = '{3'b000, 8'd5,   8'd5,   1'b0, 1'b0, 2};
        vecs[4]  = '{3'b010, 8'd5,   8'd0,   1'b0, 1'b1, 2};
        vecs[5]  = '{3'b010, 8'd6,   8'd250, 1'b1, 1'b0, 2};
        vecs[6]  = '{3'b000, 8'd13,  8'd13,  1'b0, 1'b0, 2};
        vecs[7]  = '{3'b110, 8'd11,  8'd143, 1'b0, 1'b0, 10};
        vecs[8]  = '{3'b000, 8'd20,  8'd20,  1'b0, 1'b0, 2};
        vecs[9]  = '{3'b110, 8'd20,  8'd144, 1'b1, 1'b0, 10};
        vecs[10] = '{3'b000, 8'hF0,  8'hF0,  1'b0, 1'b0, 2};
        vecs[11] = '{3'b011, 8'h3C,  8'h30,  1'b0, 1'b0, 2};
        vecs[12] = '{3'b100, 8'h0F,  8'h3F,  1'b0, 1'b0, 2};
        vecs[13] = '{3'b101, 8'hFF,  8'hC0,  1'b0, 1'b0, 2};
        vecs[14] = '{3'b111, 8'h55,  8'd0,   1'b0, 1'b1, 2};
        vecs[15] = '{3'b001, 8'h10,  8'h10,  1'b0, 1'b0, 2};
        vecs[16] = '{3'b000, 8'd0,   8'd0,   1'b0, 1'b1, 2};
        vecs[17] = '{3'b110, 8'h99,  8'd0,   1'b0, 1'b1, 10};

        // Reset state, sampled in the first cycle after rst drops.
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        acc_rst = 1'b0;
        checkOutput("rst_op_ready", int'(op_ready), 1);
        checkOutput("rst_busy",     int'(busy),     0);
        checkOutput("rst_acc_d",    int'(acc_d),    0);
        checkOutput("rst_ldacc",    int'(ldacc),    0);
        checkOutput("rst_en",       int'(en),       0);
        checkOutput("rst_carry",    int'(carry),    0);
        checkOutput("rst_zero",     int'(zero),     0);

        // Table of single operations through the closed loop.
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].op, vecs[i].b, lat);
            checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            checkOutput($sformatf("v%0d_en", i), int'(en), 1);
            checkOutput($sformatf("v%0d_acc_d", i), int'(acc_d), int'(vecs[i].exp_res));
            @(negedge clk);
            checkOutput($sformatf("v%0d_ldacc_off", i), int'(ldacc), 0);
            checkOutput($sformatf("v%0d_q", i), int'(acc_q), int'(vecs[i].exp_res));
            checkOutput($sformatf("v%0d_carry", i), int'(carry), int'(vecs[i].exp_carry));
            checkOutput($sformatf("v%0d_zero", i), int'(zero), int'(vecs[i].exp_zero));
        end

        // Reset during the fourth MUL cycle aborts without a write, and reset
        // still beats a pending op_valid in IDLE.
        applyStimulus(3'b000, 8'd77, lat);
        @(negedge clk);
        checkOutput("abort_pre_q", int'(acc_q), 77);
        base     = pulse_count;
        opcode   = 3'b110;
        operand  = 8'd3;
        op_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_busy",     int'(busy),     1);
        checkOutput("abort_op_ready", int'(op_ready), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        op_valid = 1'b0;
        checkOutput("abort_ready_after", int'(op_ready), 1);
        checkOutput("abort_acc_d",       int'(acc_d),    0);
        repeat (12) @(negedge clk);
        checkOutput("abort_no_strobe", pulse_count - base, 0);
        checkOutput("abort_q_kept",    int'(acc_q),        77);

        // op_valid held continuously: accepted once per IDLE visit, each
        // accept seeing the freshly written accumulator.
        applyStimulus(3'b000, 8'd10, lat);
        @(negedge clk);
        base     = pulse_count;
        opcode   = 3'b001;
        operand  = 8'd1;
        op_valid = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        checkOutput("b2b_strobes", pulse_count - base, 2);
        checkOutput("b2b_q",       int'(acc_q),        12);
        repeat (4) @(negedge clk);
        checkOutput("b2b_no_extra", pulse_count - base, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
